// File: rtl/cg_pkg.sv
// Shared types and constants for the clock-gated skid receiver.
package cg_pkg;

  typedef enum logic [1:0] {
    CG_IDLE   = 2'd0,
    CG_ACTIVE = 2'd1,
    CG_HOLD   = 2'd2
  } cg_state_e;

  localparam int CG_DEPTH = 2;

  // The idle timer never holds more than IDLE_HOLD-1, so clog2(IDLE_HOLD) bits suffice.
  function automatic int cg_timer_width(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/cg_idle_timer.sv
// Hysteresis down-counter: clear wins over load, load wins over decrement.
module cg_idle_timer #(
  parameter int W = 1,
  parameter logic [W-1:0] LOAD_VAL = '0
) (
  input  logic gclk,
  input  logic rst_n,
  input  logic load_i,
  input  logic clear_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (load_i)
      cnt_d = LOAD_VAL;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cg_skid_receiver.sv
// Two-entry valid/ready skid buffer on a gated clock that drives its own clock request.
// Optional active-cycle counter is built only when CG_STATS_EN is defined.
module cg_skid_receiver
  import cg_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int IDLE_HOLD = 4,
  parameter int STAT_W    = 16
) (
  input  logic              gclk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              cg_req,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_active,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a beat moves on a gclk edge when valid and ready are both high;
  // in_ready and out_valid depend only on registered occupancy.

  localparam int TW = cg_timer_width(IDLE_HOLD);
  localparam logic [TW-1:0] T_LOAD = TW'((IDLE_HOLD > 0) ? IDLE_HOLD - 1 : 0);

  logic [1:0]       count_q, count_d;
  logic             head_q, tail_q;
  logic [WIDTH-1:0] mem_q [CG_DEPTH];
  logic             push, pop;

  cg_state_e state_q, state_d;
  logic      t_load, t_clear, t_dec, t_zero;

  assign in_ready  = (count_q != 2'(CG_DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[head_q];
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      for (int i = 0; i < CG_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        mem_q[tail_q] <= in_data;
        tail_q        <= ~tail_q;
      end
      if (pop)
        head_q <= ~head_q;
    end
  end

  cg_idle_timer #(
    .W        (TW),
    .LOAD_VAL (T_LOAD)
  ) u_idle_timer (
    .gclk    (gclk),
    .rst_n   (rst_n),
    .load_i  (t_load),
    .clear_i (t_clear),
    .dec_i   (t_dec),
    .zero_o  (t_zero)
  );

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n)
      state_q <= CG_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    t_load  = 1'b0;
    t_clear = 1'b0;
    t_dec   = 1'b0;
    case (state_q)
      CG_IDLE:
        if (in_valid) state_d = CG_ACTIVE;
      CG_ACTIVE:
        // Leave only once the buffer drains with nothing else arriving.
        if ((count_d == 2'd0) && !in_valid) begin
          if (IDLE_HOLD == 0) begin
            state_d = CG_IDLE;
          end else begin
            state_d = CG_HOLD;
            t_load  = 1'b1;
          end
        end
      CG_HOLD:
        if (in_valid) begin
          state_d = CG_ACTIVE;
          t_clear = 1'b1;
        end else if (t_zero) begin
          state_d = CG_IDLE;
        end else begin
          t_dec = 1'b1;
        end
      default:
        state_d = CG_IDLE;
    endcase
  end

  // in_valid is the only combinational term: it must wake a stopped clock.
  always_comb begin
    cg_req      = in_valid | (count_q != 2'd0) | (state_q != CG_IDLE);
    dbg_state_o = state_q;
  end

`ifdef CG_STATS_EN
  logic [STAT_W-1:0] stat_q;

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n)
      stat_q <= '0;
    else if (stat_clr)
      stat_q <= '0;
    else if ((state_q != CG_IDLE) && (stat_q != '1))
      stat_q <= stat_q + STAT_W'(1);
  end

  assign stat_active = stat_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_active     = '0;
`endif

endmodule
